// File: rtl/ib_pkg.sv
// Shared types and helpers for the ping-pong input buffer.
// Bank ring state, index-width derivation and modulo bank increment.
package ib_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefDepth     = 16;
  localparam int unsigned DefNumBanks  = 2;

  // Index width for n entries, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Modulo increment that wraps correctly for non-power-of-two ring sizes.
  function automatic int unsigned next_bank(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ib_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register holds its value in cycles without a read.
module ib_sdp_ram
  import ib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned WORDS      = DefDepth * DefNumBanks,
  localparam int unsigned RAW       = clog2_min1(WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAW-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [RAW-1:0]        raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_input_buffer.sv
// Multi-bank double-buffered input buffer: producer fills one bank while the
// consumer drains a committed one; banks cycle EMPTY -> FULL -> EMPTY.
module pingpong_input_buffer
  import ib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned NUM_BANKS  = DefNumBanks,
  localparam int unsigned AW        = clog2_min1(DEPTH),
  localparam int unsigned BW        = clog2_min1(NUM_BANKS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_commit,
  output logic                         wr_ready,
  output logic                         wr_drop,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  input  logic                         rd_release,
  output logic                         rd_ready,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         addr_err,
  output logic [BW-1:0]                wr_bank,
  output logic [BW-1:0]                rd_bank
);

  localparam int unsigned Words    = NUM_BANKS * DEPTH;
  localparam int unsigned RAW      = clog2_min1(Words);
  localparam logic [AW:0] DepthLim = (AW + 1)'(DEPTH);

  bank_state_t state_q [NUM_BANKS];
  bank_state_t state_d [NUM_BANKS];

  logic [BW-1:0] wr_bank_q, wr_bank_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;
  logic          rd_valid_q;
  logic          rd_sel_q;
  logic          wr_drop_q;
  logic          addr_err_q;

  logic wr_in_range, rd_in_range;
  logic wr_accept, rd_take, rd_hit;
  logic commit_ok, release_ok;

  logic [RAW-1:0]        waddr_flat, raddr_flat;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_ready    = (state_q[wr_bank_q] == BANK_EMPTY);
  assign rd_ready    = (state_q[rd_bank_q] == BANK_FULL);
  assign wr_in_range = ({1'b0, wr_addr} < DepthLim);
  assign rd_in_range = ({1'b0, rd_addr} < DepthLim);
  assign wr_accept   = wr_en & wr_ready & wr_in_range;
  assign rd_take     = rd_en & rd_ready;
  assign rd_hit      = rd_take & rd_in_range;
  assign commit_ok   = wr_commit & wr_ready;
  assign release_ok  = rd_release & rd_ready;

  assign waddr_flat = RAW'(wr_bank_q) * RAW'(DEPTH) + RAW'(wr_addr);
  assign raddr_flat = RAW'(rd_bank_q) * RAW'(DEPTH) + RAW'(rd_addr);

  // Commit and release can never hit the same bank: one needs EMPTY, the other FULL.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (commit_ok) begin
      state_d[wr_bank_q] = BANK_FULL;
      wr_bank_d          = BW'(next_bank(32'(wr_bank_q), NUM_BANKS));
    end
    if (release_ok) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = BW'(next_bank(32'(rd_bank_q), NUM_BANKS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        state_q[i] <= BANK_EMPTY;
      end
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_drop_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_take;
      // rd_sel_q picks RAM word vs. zero; it holds with the RAM register between reads.
      if (rd_take) begin
        rd_sel_q <= rd_in_range;
      end
      wr_drop_q  <= (wr_en | wr_commit) & ~wr_ready;
      addr_err_q <= (wr_en & wr_ready & ~wr_in_range) | (rd_take & ~rd_in_range);
    end
  end

  ib_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (Words)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept & ~rst),
    .waddr (waddr_flat),
    .wdata (wr_data),
    .re    (rd_hit & ~rst),
    .raddr (raddr_flat),
    .rdata (ram_rdata)
  );

  assign rd_data  = rd_sel_q ? ram_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign wr_drop  = wr_drop_q;
  assign addr_err = addr_err_q;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;

endmodule
